// File: rtl/multi_digit_updown_counter_if.sv
// Bus bundle for the multi-digit up/down counter: button, mode and load inputs
// plus the count, segment and flag outputs. The counter takes the slave modport.
interface multi_digit_updown_counter_if #(
  parameter int DIGITS = 3
);
  logic [1:0]          i_Push;
  logic                i_Mode;
  logic                i_Load;
  logic [4*DIGITS-1:0] i_LoadVal;
  logic [4*DIGITS-1:0] o_LED;
  logic [7*DIGITS-1:0] o_FND;
  logic                o_Ovf;
  logic                o_Udf;

  modport master (
    output i_Push, i_Mode, i_Load, i_LoadVal,
    input  o_LED, o_FND, o_Ovf, o_Udf
  );

  modport slave (
    input  i_Push, i_Mode, i_Load, i_LoadVal,
    output o_LED, o_FND, o_Ovf, o_Udf
  );
endinterface

// File: rtl/multi_digit_updown_counter.sv
// N-digit up/down counter in a configurable radix, driven by synchronised push-button
// edges, with parallel load, wrap/saturate mode, over/underflow pulses and 7-segment decode.
module multi_digit_updown_counter #(
  parameter int DIGITS         = 3,
  parameter int RADIX          = 10,
  parameter int BLANK_LZ       = 0,
  parameter int FND_ACTIVE_LOW = 0
) (
  input logic i_Clk,
  input logic i_Rst,
  multi_digit_updown_counter_if.slave bus
);
  localparam logic [3:0] MAX_DIGIT = 4'(RADIX - 1);

  logic [1:0] s1_reg, s2_reg, prev_reg;
  logic [1:0] step_pulse;

  logic [DIGITS-1:0][3:0] count_reg, count_next;
  logic [DIGITS-1:0][3:0] inc_val, dec_val, load_val;
  logic [DIGITS:0]        carry, borrow, lit;
  logic                   ovf_reg, ovf_next, udf_reg, udf_next;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      s1_reg   <= 2'b00;
      s2_reg   <= 2'b00;
      prev_reg <= 2'b00;
    end else begin
      s1_reg   <= bus.i_Push;
      s2_reg   <= s1_reg;
      prev_reg <= s2_reg;
    end
  end

  assign step_pulse = s2_reg & ~prev_reg;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b0111111;
      4'h1: seg7 = 7'b0000110;
      4'h2: seg7 = 7'b1011011;
      4'h3: seg7 = 7'b1001111;
      4'h4: seg7 = 7'b1100110;
      4'h5: seg7 = 7'b1101101;
      4'h6: seg7 = 7'b1111101;
      4'h7: seg7 = 7'b0000111;
      4'h8: seg7 = 7'b1111111;
      4'h9: seg7 = 7'b1101111;
      4'hA: seg7 = 7'b1110111;
      4'hB: seg7 = 7'b1111100;
      4'hC: seg7 = 7'b0111001;
      4'hD: seg7 = 7'b1011110;
      4'hE: seg7 = 7'b1111001;
      default: seg7 = 7'b1110001;
    endcase
  endfunction

  // Carry/borrow ripple through all digits in one cycle; the chain ends tell max/zero.
  assign carry[0]       = 1'b1;
  assign borrow[0]      = 1'b1;
  assign lit[DIGITS]    = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] ld_digit;
      logic [6:0] seg;
      logic       blank;

      assign ld_digit      = bus.i_LoadVal[4*gi +: 4];
      assign load_val[gi]  = (ld_digit > MAX_DIGIT) ? MAX_DIGIT : ld_digit;

      assign carry[gi+1]   = carry[gi] & (count_reg[gi] == MAX_DIGIT);
      assign inc_val[gi]   = !carry[gi] ? count_reg[gi] :
                             (count_reg[gi] == MAX_DIGIT) ? 4'd0 : count_reg[gi] + 4'd1;

      assign borrow[gi+1]  = borrow[gi] & (count_reg[gi] == 4'd0);
      assign dec_val[gi]   = !borrow[gi] ? count_reg[gi] :
                             (count_reg[gi] == 4'd0) ? MAX_DIGIT : count_reg[gi] - 4'd1;

      // A digit is "lit" when it or any more significant digit is non-zero.
      assign lit[gi]       = lit[gi+1] | (count_reg[gi] != 4'd0);
      assign blank         = (BLANK_LZ != 0) && (gi != 0) && !lit[gi];
      assign seg           = blank ? 7'b0000000 : seg7(count_reg[gi]);
      assign bus.o_FND[7*gi +: 7] = (FND_ACTIVE_LOW != 0) ? ~seg : seg;
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    ovf_next   = 1'b0;
    udf_next   = 1'b0;
    if (bus.i_Load) begin
      count_next = load_val;
    end else if (step_pulse == 2'b01) begin
      ovf_next = carry[DIGITS];
      if (!(carry[DIGITS] && bus.i_Mode)) count_next = inc_val;
    end else if (step_pulse == 2'b10) begin
      udf_next = borrow[DIGITS];
      if (!(borrow[DIGITS] && bus.i_Mode)) count_next = dec_val;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      udf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      udf_reg   <= udf_next;
    end
  end

  assign bus.o_LED = count_reg;
  assign bus.o_Ovf = ovf_reg;
  assign bus.o_Udf = udf_reg;
endmodule
